// File: rtl/id_regfile_hazard.sv
// id_regfile_hazard: decode-stage 32x32 register file with load-use stall
// detection and a saturating stall-cycle counter.
// Optional build macro: REGFILE_BYPASS_EN -- same-cycle write-through from
// the WB port to the read ports (default build: reads see stored data only).

// One read port: combinational lookup with r0 hardwired to zero and an
// optional write-through from the WB port.
module id_regfile_rdport #(
  parameter bit BYPASS = 1'b0
) (
  input  logic [4:0]        addr,
  input  logic [31:0][31:0] mem,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  output logic [31:0]       data
);
  logic byp_hit;

  assign byp_hit = BYPASS && wb_we && (wb_addr != 5'd0) && (wb_addr == addr);

  // r0 wins over everything, then the WB write-through, then storage
  always_comb begin
    data = mem[addr];
    if (addr == 5'd0)  data = '0;
    else if (byp_hit)  data = wb_data;
  end
endmodule

module id_regfile_hazard (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [4:0]  RSAddr,
  input  logic [4:0]  RTAddr,
  input  logic        UsesRS,
  input  logic        UsesRT,
  input  logic        WBWriteEN,
  input  logic [4:0]  WBAddr,
  input  logic [31:0] WBData,
  input  logic        EXMemRead,
  input  logic [4:0]  EXDstAddr,
  output logic [31:0] RegData1,
  output logic [31:0] RegData2,
  output logic        Stall,
  output logic [31:0] StallCount
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [31:0][VEC_W-1:0]          mem;
  logic [NUM_LANES-1:0][4:0]       rd_addr;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_data;
  logic [NUM_LANES-1:0]            rd_uses;
  logic [NUM_LANES-1:0]            rd_hit;
  logic [31:0]                     stall_cnt;

  assign rd_addr = {RTAddr, RSAddr};
  assign rd_uses = {UsesRT, UsesRS};

  // Storage; entry 0 is never written so it stays at its reset value.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)                               mem <= '0;
    else if (WBWriteEN && WBAddr != 5'd0)    mem[WBAddr] <= WBData;
  end

  // Lane 0 serves RS, lane 1 serves RT; mem and WB port are broadcast.
  id_regfile_rdport #(.BYPASS(BYPASS)) u_rd [NUM_LANES-1:0] (
    .addr    (rd_addr),
    .mem     (mem),
    .wb_we   (WBWriteEN),
    .wb_addr (WBAddr),
    .wb_data (WBData),
    .data    (rd_data)
  );

  assign RegData1 = rd_data[0];
  assign RegData2 = rd_data[1];

  // Per-lane match of a used source against the load destination in EX.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++)
      rd_hit[l] = rd_uses[l] && (rd_addr[l] == EXDstAddr);
  end

  // A load into r0 never creates a dependency.
  assign Stall = EXMemRead && (EXDstAddr != 5'd0) && (|rd_hit);

  // Stall-cycle counter, pinned at all-ones once it gets there.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)                              stall_cnt <= '0;
    else if (Stall && stall_cnt != '1)      stall_cnt <= stall_cnt + 32'd1;
  end

  assign StallCount = stall_cnt;
endmodule
